// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_rx_fifo_pkg                                               |
// | Purpose : Shared UART constants: parity modes, receiver FSM state        |
// |           encodings and small helper functions (parity, 3-way vote).     |
// | Ports   : none (package)                                                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package uart_rx_fifo_pkg;

  localparam int c_PARITY_NONE = 0;
  localparam int c_PARITY_EVEN = 1;
  localparam int c_PARITY_ODD  = 2;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP   = 3'd4;

  // Expected parity bit for a frame. Narrow data words are zero-padded,
  // which does not change the XOR reduction.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    case (mode)
      c_PARITY_EVEN: p = ^data;
      c_PARITY_ODD:  p = ~^data;
      default:       p = 1'b0;
    endcase
    return p;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_rx_fifo_sync_fifo                                         |
// | Purpose : Single-clock FIFO with first-word fall-through head output.    |
// | Ports   : clk, resetn      clock / synchronous active-low reset          |
// |           push_i, data_i   write request and data (ignored when full     |
// |                            unless a pop happens in the same cycle)       |
// |           pop_i            read request (ignored when empty)             |
// |           data_o           head entry, 0 when empty                      |
// |           full_o, empty_o  status                                        |
// |           count_o          entries held, 0..DEPTH                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx_fifo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_DEPTH = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             w_pop;
  logic             w_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == c_DEPTH);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap by plain overflow.
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head output is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_rx_fifo                                                   |
// | Purpose : UART receiver with 3-sample majority vote, optional parity,    |
// |           sticky error flags and a first-word fall-through RX FIFO.      |
// | Ports   : clk, resetn   clock / synchronous active-low reset             |
// |           rxd           asynchronous serial input, idle high             |
// |           rd_en         pop head entry (ignored when rd_valid=0)         |
// |           rd_data       FIFO head, rd_valid  FIFO not empty              |
// |           fifo_count    entries held                                     |
// |           parity_err, frame_err, overrun, break_det   sticky flags       |
// |           clr_err       one-cycle pulse clearing the sticky flags        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          break_det,
  input  logic                          clr_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_MID      = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] c_MID_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] c_MID_P1   = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] c_CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    c_LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_meta_q, rxs_q, rxs_prev_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 vote0_q, vote0_d, vote1_q, vote1_d;
  logic                 par_bad_q, par_bad_d;
  logic                 brk_wait_q, brk_wait_d;
  logic                 push_q, push_d;
  logic [DATA_BITS-1:0] push_data_q;
  logic                 parity_err_q, frame_err_q, overrun_q, break_det_q;

  logic                 w_vote, w_decide;
  logic                 w_set_par, w_set_frm, w_set_brk, w_set_ovr;
  logic [7:0]           w_data8;
  logic                 w_full, w_empty, w_pop, w_fifo_push;

  assign w_vote   = majority3(vote0_q, vote1_q, rxs_q);
  assign w_decide = (cnt_q == c_MID_P1);

  always_comb begin
    w_data8                = '0;
    w_data8[DATA_BITS-1:0] = shift_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    vote0_d    = vote0_q;
    vote1_d    = vote1_q;
    par_bad_d  = par_bad_q;
    brk_wait_d = brk_wait_q;
    push_d     = 1'b0;
    w_set_par  = 1'b0;
    w_set_frm  = 1'b0;
    w_set_brk  = 1'b0;

    // Free-running bit-period counter while a frame is in progress; every
    // bit is decided at the same count, one period apart.
    if (state_q != c_ST_IDLE) begin
      cnt_d = (cnt_q == c_CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == c_MID_M1) vote0_d = rxs_q;
      if (cnt_q == c_MID)    vote1_d = rxs_q;
    end

    case (state_q)
      c_ST_IDLE: begin
        // After a break, the line must return high before a new start counts.
        if (brk_wait_q) begin
          if (rxs_q) brk_wait_d = 1'b0;
        end else if (!rxs_q && rxs_prev_q) begin
          state_d = c_ST_START;
          cnt_d   = '0;
        end
      end
      c_ST_START: begin
        if (w_decide) begin
          state_d   = w_vote ? c_ST_IDLE : c_ST_DATA;
          bit_idx_d = '0;
          par_bad_d = 1'b0;
        end
      end
      c_ST_DATA: begin
        if (w_decide) begin
          shift_d   = {w_vote, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == c_LAST_BIT)
            state_d = (PARITY != c_PARITY_NONE) ? c_ST_PARITY : c_ST_STOP;
        end
      end
      c_ST_PARITY: begin
        if (w_decide) begin
          par_bad_d = (w_vote != parity_bit(w_data8, PARITY));
          state_d   = c_ST_STOP;
        end
      end
      c_ST_STOP: begin
        // Decide at mid-bit and rearm immediately for half a bit of resync slack.
        if (w_decide) begin
          state_d = c_ST_IDLE;
          if (w_vote) begin
            push_d    = 1'b1;
            w_set_par = par_bad_q;
          end else if (shift_q == '0) begin
            w_set_brk  = 1'b1;
            brk_wait_d = 1'b1;
          end else begin
            w_set_frm = 1'b1;
          end
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // Byte is lost only when the FIFO is full and the head is not leaving.
  assign w_set_ovr   = push_q & w_full & ~rd_en;
  assign w_pop       = rd_en & ~w_empty;
  assign w_fifo_push = push_q & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      state_q      <= c_ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      vote0_q      <= 1'b1;
      vote1_q      <= 1'b1;
      par_bad_q    <= 1'b0;
      brk_wait_q   <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rxd;
      rxs_q        <= rx_meta_q;
      rxs_prev_q   <= rxs_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      vote0_q      <= vote0_d;
      vote1_q      <= vote1_d;
      par_bad_q    <= par_bad_d;
      brk_wait_q   <= brk_wait_d;
      push_q       <= push_d;
      push_data_q  <= shift_d;
      // A new event wins over a simultaneous clear.
      parity_err_q <= w_set_par | (parity_err_q & ~clr_err);
      frame_err_q  <= w_set_frm | (frame_err_q  & ~clr_err);
      overrun_q    <= w_set_ovr | (overrun_q    & ~clr_err);
      break_det_q  <= w_set_brk | (break_det_q  & ~clr_err);
    end
  end

  uart_rx_fifo_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (w_fifo_push),
    .data_i  (push_data_q),
    .pop_i   (w_pop),
    .data_o  (rd_data),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (fifo_count)
  );

  assign rd_valid   = ~w_empty;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_det_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_uart_rx_fifo                                                |
// | Purpose : Scoreboard bench for uart_rx_fifo. Three instances:            |
// |           A default (no parity, depth 16), P odd parity, O depth 4.      |
// |           Accepted bytes are queued at send time; monitors compare the   |
// |           head against the queue on every pop.                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_rx_fifo;

  localparam int CPB = 217;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic resetn  [3];
  logic rxd     [3];
  logic rd_en   [3];
  logic clr_err [3];

  logic [7:0] rd_data_a, rd_data_p, rd_data_o;
  logic       rd_valid_a, rd_valid_p, rd_valid_o;
  logic [4:0] cnt_a, cnt_p;
  logic [2:0] cnt_o;
  logic       par_a, frm_a, ovr_a, brk_a;
  logic       par_p, frm_p, ovr_p, brk_p;
  logic       par_o, frm_o, ovr_o, brk_o;
  logic [3:0] flags_a, flags_p, flags_o;

  // Flag vectors: {break_det, overrun, frame_err, parity_err}
  assign flags_a = {brk_a, ovr_a, frm_a, par_a};
  assign flags_p = {brk_p, ovr_p, frm_p, par_p};
  assign flags_o = {brk_o, ovr_o, frm_o, par_o};

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)) u_a (
    .clk(clk), .resetn(resetn[0]), .rxd(rxd[0]), .rd_en(rd_en[0]),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .fifo_count(cnt_a),
    .parity_err(par_a), .frame_err(frm_a), .overrun(ovr_a), .break_det(brk_a),
    .clr_err(clr_err[0]));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16)) u_p (
    .clk(clk), .resetn(resetn[1]), .rxd(rxd[1]), .rd_en(rd_en[1]),
    .rd_data(rd_data_p), .rd_valid(rd_valid_p), .fifo_count(cnt_p),
    .parity_err(par_p), .frame_err(frm_p), .overrun(ovr_p), .break_det(brk_p),
    .clr_err(clr_err[1]));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_o (
    .clk(clk), .resetn(resetn[2]), .rxd(rxd[2]), .rd_en(rd_en[2]),
    .rd_data(rd_data_o), .rd_valid(rd_valid_o), .fifo_count(cnt_o),
    .parity_err(par_o), .frame_err(frm_o), .overrun(ovr_o), .break_det(brk_o),
    .clr_err(clr_err[2]));

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_p[$];
  logic [7:0] q_o[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard compare for one pop observed on instance idx.
  task automatic mon(input int idx, input logic valid, input logic [7:0] data);
    logic [7:0] e;
    logic       have;
    if (!(rd_en[idx] && valid)) return;
    have = 1'b0;
    e    = '0;
    case (idx)
      0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      1: if (q_p.size() > 0) begin e = q_p.pop_front(); have = 1'b1; end
      default: if (q_o.size() > 0) begin e = q_o.pop_front(); have = 1'b1; end
    endcase
    n_checks++;
    if (!have) begin
      n_fail++;
      $display("FAIL pop_%0d: got 0x%0h, expected no byte (queue empty)", idx, data);
    end else if (data !== e) begin
      n_fail++;
      $display("FAIL pop_%0d: got 0x%0h, expected 0x%0h", idx, data, e);
    end
  endtask

  always begin @(negedge clk); #5; mon(0, rd_valid_a, rd_data_a); end
  always begin @(negedge clk); #5; mon(1, rd_valid_p, rd_data_p); end
  always begin @(negedge clk); #5; mon(2, rd_valid_o, rd_data_o); end

  // All stimulus tasks start and end on a falling clock edge.
  task automatic drive_bit(input int idx, input logic b);
    rxd[idx] = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int idx, input int n);
    for (int i = 0; i < n; i++) drive_bit(idx, 1'b1);
  endtask

  task automatic send_frame(input int idx, input logic [7:0] d, input logic has_par,
                            input logic pbit, input logic stop);
    drive_bit(idx, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(idx, d[i]);
    if (has_par) drive_bit(idx, pbit);
    drive_bit(idx, stop);
  endtask

  task automatic pop(input int idx);
    rd_en[idx] = 1'b1;
    @(negedge clk);
    rd_en[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic clr_pulse(input int idx);
    clr_err[idx] = 1'b1;
    @(negedge clk);
    clr_err[idx] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      resetn[i] = 1'b0; rxd[i] = 1'b1; rd_en[i] = 1'b0; clr_err[i] = 1'b0;
    end
    repeat (5) @(negedge clk);

    check("rst_valid_a", int'(rd_valid_a), 0);
    check("rst_cnt_a",   int'(cnt_a), 0);
    check("rst_data_a",  int'(rd_data_a), 0);
    check("rst_flags_a", int'(flags_a), 0);
    check("rst_cnt_p",   int'(cnt_p), 0);
    check("rst_cnt_o",   int'(cnt_o), 0);

    for (int i = 0; i < 3; i++) resetn[i] = 1'b1;
    @(negedge clk);
    idle_bits(0, 2);

    // Two bytes, no pops, then drain.
    send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1); q_a.push_back(8'h34);
    send_frame(0, 8'h35, 1'b0, 1'b0, 1'b1); q_a.push_back(8'h35);
    idle_bits(0, 1);
    check("two_cnt",  int'(cnt_a), 2);
    check("two_head", int'(rd_data_a), 8'h34);
    pop(0);
    check("one_cnt",  int'(cnt_a), 1);
    check("one_head", int'(rd_data_a), 8'h35);
    pop(0);
    check("drain_valid", int'(rd_valid_a), 0);
    check("drain_flags", int'(flags_a), 0);

    // Stop bit low with non-zero data.
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    idle_bits(0, 2);
    check("frm_flags", int'(flags_a), 4'b0010);
    check("frm_cnt",   int'(cnt_a), 0);
    clr_pulse(0);
    check("frm_clr",   int'(flags_a), 0);

    // Break: line low for 12 bit periods.
    for (int i = 0; i < 12; i++) drive_bit(0, 1'b0);
    idle_bits(0, 2);
    check("brk_flags", int'(flags_a), 4'b1000);
    check("brk_cnt",   int'(cnt_a), 0);
    clr_pulse(0);
    send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1); q_a.push_back(8'h34);
    idle_bits(0, 1);
    check("brk_next_cnt", int'(cnt_a), 1);
    pop(0);

    // Two-clock glitch on the idle line.
    rxd[0] = 1'b0;
    repeat (2) @(negedge clk);
    idle_bits(0, 2);
    check("glitch_cnt",   int'(cnt_a), 0);
    check("glitch_flags", int'(flags_a), 0);

    // Reset during data bit 3 with a byte already held: everything clears.
    send_frame(0, 8'h35, 1'b0, 1'b0, 1'b1);
    idle_bits(0, 1);
    check("pre_rst_cnt", int'(cnt_a), 1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rxd[0] = 1'b0;
    repeat (100) @(negedge clk);
    resetn[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_cnt",   int'(cnt_a), 0);
    check("mid_rst_valid", int'(rd_valid_a), 0);
    check("mid_rst_data",  int'(rd_data_a), 0);
    resetn[0] = 1'b1;
    idle_bits(0, 3);
    check("post_rst_cnt",   int'(cnt_a), 0);
    check("post_rst_flags", int'(flags_a), 0);
    send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1); q_a.push_back(8'h34);
    idle_bits(0, 1);
    check("post_rst_rx", int'(cnt_a), 1);
    pop(0);

    // Odd parity: 0x34 has three ones, so the correct parity bit is 0.
    idle_bits(1, 1);
    send_frame(1, 8'h34, 1'b1, 1'b0, 1'b1); q_p.push_back(8'h34);
    idle_bits(1, 1);
    check("par_ok_flags", int'(flags_p), 0);
    check("par_ok_cnt",   int'(cnt_p), 1);
    send_frame(1, 8'h34, 1'b1, 1'b1, 1'b1); q_p.push_back(8'h34);
    idle_bits(1, 1);
    check("par_bad_flags", int'(flags_p), 4'b0001);
    check("par_bad_cnt",   int'(cnt_p), 2);
    clr_pulse(1);
    check("par_clr", int'(flags_p), 0);
    pop(1);
    pop(1);
    check("par_drain", int'(rd_valid_p), 0);

    // Depth-4 FIFO: the fifth byte overruns.
    idle_bits(2, 1);
    for (int i = 1; i <= 5; i++) begin
      send_frame(2, 8'(i), 1'b0, 1'b0, 1'b1);
      if (i <= 4) q_o.push_back(8'(i));
    end
    idle_bits(2, 1);
    check("ovr_cnt",   int'(cnt_o), 4);
    check("ovr_flags", int'(flags_o), 4'b0100);
    check("ovr_head",  int'(rd_data_o), 8'h01);
    for (int i = 0; i < 4; i++) pop(2);
    check("ovr_drain", int'(rd_valid_o), 0);

    check("sb_left_a", q_a.size(), 0);
    check("sb_left_p", q_p.size(), 0);
    check("sb_left_o", q_o.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
